// File: rtl/mul_seq.sv
// Sequential unsigned shift-and-add multiplier: one width-bit ripple add per RUN cycle.
// Optional MUL_OVF_EN adds an ovf output flagging a product that exceeds width bits.
module mul_seq #(
    parameter int width = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] product
`ifdef MUL_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int CNT_W = $clog2(width) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   mcand_q, mcand_d;
    logic [width-1:0]   acc_hi_q, acc_hi_d;
    logic [width-1:0]   acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*width-1:0] product_q, product_d;
`ifdef MUL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [width-1:0]   add_b;
    logic [width-1:0]   sum;
    logic               c_out;
    logic [2*width-1:0] step;

    always_comb begin : ripple
        logic c;
        c     = 1'b0;
        sum   = '0;
        add_b = acc_lo_q[0] ? mcand_q : '0;
        for (int i = 0; i < width; i++) begin
            sum[i] = acc_hi_q[i] ^ add_b[i] ^ c;
            c      = (acc_hi_q[i] & add_b[i]) | (c & (acc_hi_q[i] ^ add_b[i]));
        end
        c_out = c;
    end

    // {c,sum,acc_lo} shifted right by one; width==1 has no acc_lo bits left to keep.
    generate
        if (width > 1) begin : g_wide
            assign step = {c_out, sum, acc_lo_q[width-1:1]};
        end else begin : g_one
            assign step = {c_out, sum};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MUL_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = step;
                cnt_d                = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(width - 1)) begin
                    product_d = step;
`ifdef MUL_OVF_EN
                    ovf_d     = |step[2*width-1:width];
`endif
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef MUL_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MUL_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
`ifdef MUL_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes a*b expectations, a negedge monitor checks each done.
module tb_mul_seq;

    localparam int W  = 6;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [PW-1:0] product;
`ifdef MUL_OVF_EN
    logic          ovf;
`endif

    mul_seq #(.width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
`ifdef MUL_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] prod;
        logic          ovf;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [PW-1:0] last_prod = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer multiply; overflow means the product needs more than W bits.
    task automatic push_exp(input int unsigned x, input int unsigned y);
        exp_t        e;
        int unsigned p;
        p      = x * y;
        e.prod = PW'(p);
        e.ovf  = (p >= (32'd1 << W));
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_prod = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("product", product, e.prod);
`ifdef MUL_OVF_EN
                check("ovf", ovf, e.ovf);
`endif
            end
            last_prod = product;
        end else begin
            check("product_stable", product, last_prod);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy || done) && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) check("idle_timeout", 1, 0);
    endtask

    // Runs one operation and checks busy/done timing; toggle scrambles inputs during RUN and DONE.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit toggle);
        bit ok;
        wait_idle();
        a = x; b = y; start = 1'b1;
        push_exp(x, y);
        tick();
        start = 1'b0;
        ok = busy && !done;
        for (int i = 1; i < W; i++) begin
            if (toggle) begin
                a = W'($urandom); b = W'($urandom); start = 1'($urandom);
            end
            tick();
            ok = ok && busy && !done;
        end
        check("busy_window", ok, 1);
        if (toggle) begin
            a = W'($urandom); b = W'($urandom); start = 1'b0;
        end
        tick();
        check("done_pulse", {busy, done}, 2'b01);
        if (toggle) begin
            a = W'($urandom); b = W'($urandom); start = 1'b1;
        end
        tick();
        start = 1'b0;
        check("back_to_idle", {busy, done}, 2'b00);
        tick();
        check("no_restart", {busy, done}, 2'b00);
    endtask

    initial begin
        int   dones;
        int   t_done[3];
        int   cyc;
        bit   ok;
        logic [W-1:0] x, y;

        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        #1 rst = 1'b1;
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
`ifdef MUL_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        @(posedge clk); #1 rst = 1'b0;
        tick();

        run_op(6'd5, 6'd7, 1'b0);
        run_op(6'd63, 6'd63, 1'b0);
        run_op(6'd0, 6'd42, 1'b0);
        run_op(6'd42, 6'd0, 1'b0);
        run_op(6'd1, 6'd63, 1'b0);
        run_op(6'd3, 6'd4, 1'b1);

        // Start held high: the FSM re-accepts on each return to IDLE, every W+2 cycles.
        wait_idle();
        a = 6'd7; b = 6'd9; start = 1'b1;
        repeat (3) push_exp(7, 9);
        dones = 0; cyc = 0;
        while (dones < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (done) begin
                t_done[dones] = cyc;
                dones++;
                if (dones == 3) start = 1'b0;
            end
        end
        check("held_done_count", dones, 3);
        check("held_interval1", t_done[1] - t_done[0], W + 2);
        check("held_interval2", t_done[2] - t_done[1], W + 2);
        tick();
        tick();
        check("held_stop", {busy, done}, 2'b00);

        // Asynchronous reset in the third RUN cycle aborts with no done and no product.
        wait_idle();
        a = 6'd10; b = 6'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        tick();
        rst = 1'b0;
        ok = 1'b1;
        repeat (W + 3) begin
            tick();
            ok = ok && !done && !busy;
        end
        check("abort_no_done", ok, 1);
        run_op(6'd2, 6'd3, 1'b0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(7))
                0:       x = '0;
                1:       x = '1;
                default: x = W'($urandom);
            endcase
            case ($urandom_range(7))
                0:       y = '0;
                1:       y = '1;
                default: y = W'($urandom);
            endcase
            run_op(x, y, 1'($urandom));
        end

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential unsigned shift-and-add multiplier for the ALU datapath. Width is a parameter.
- Accepts two width-bit operands on a start strobe and runs one width-bit add per clock, with carry-out, through an internal ripple adder.
- Delivers a 2*width-bit product with a done pulse.
- Sits directly downstream of operand selection. It drives the adder's a/b/carry-in and consumes its sum and carry-out every RUN cycle.

Parameters:
- width, 6, operand width in bits; product is 2*width bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  width  multiplicand, captured when start is accepted.
- b  input  width  multiplier, captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*width  registered result; held until the next completion.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE; busy=0, done=0, product=0.
  - internal mcand, acc_hi, acc_lo and cnt all 0.
- Internal registers:
  - mcand[width-1:0], acc_hi[width-1:0], acc_lo[width-1:0] (holds the multiplier, shifted out LSB-first).
  - cnt, ceil(log2(width))+1 bits.
- IDLE:
  - If start=1 at a rising edge: mcand<=a, acc_lo<=b, acc_hi<=0, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN, each edge (one step):
  - Adder operands: acc_hi + (acc_lo[0] ? mcand : 0), carry-in 0, giving {c,sum} of width+1 bits.
  - Update: {acc_hi,acc_lo} <= {c,sum,acc_lo[width-1:1]}, i.e. a right shift by one of {c,sum,acc_lo}.
  - cnt<=cnt+1.
  - When cnt==width-1 at the edge: the updated {acc_hi,acc_lo} is written to product at the same edge, and state<=DONE.
- DONE: done=1 for exactly one cycle; state<=IDLE at the next edge. start is ignored in DONE.
- Latency:
  - start accepted at edge k → busy=1 from edge k through edge k+width.
  - product updated and done=1 after edge k+width.
  - Next start is accepted at edge k+width+2 at the earliest.
- busy = (state==RUN); done = (state==DONE). Both decode directly from state registers; no combinational path from inputs.
- start asserted during RUN or DONE is ignored; no queuing. a and b changing during RUN have no effect.
- product holds its previous value during RUN and changes only at the final RUN edge.
- Arithmetic is unsigned. Max result (2^width-1)^2 fits in 2*width bits; no truncation. Adder carry-out is always retained in the shift.
- Reset asserted mid-RUN aborts immediately to the reset values; no done pulse and no partial product.
- width=1 must work: RUN lasts one cycle.

Optional Feature:
- Macro: MUL_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is registered at the same edge as product.
  - ovf = 1 iff product[2*width-1:width] != 0, i.e. the result does not fit the width-bit ALU result bus.
  - ovf holds with product.
- Undefined: no ovf port or logic; behaviour otherwise identical.

Test Plan:
- Reset then start with a=5, b=7 (width=6), edge k:
  - busy=1 for 6 cycles.
  - done=1 one cycle after edge k+6, product=35.
  - ovf=0 if MUL_OVF_EN.
- a=63, b=63 → product=3969 (0xF81), done one cycle. ovf=1 if MUL_OVF_EN.
- a=0, b=42 → 0; then a=42, b=0 → 0; then a=1, b=63 → 63. Each completes in exactly 6 RUN cycles.
- Start a=3, b=4, then pulse start with a=9, b=9 and toggle a/b during RUN and during DONE:
  - product=12.
  - No second operation begins until a start seen in IDLE.
  - A start held high continuously restarts at IDLE, with done every 8 cycles.
- Assert rst asynchronously (mid-cycle) at RUN cycle 3 of a=10, b=10:
  - busy=0, done=0, product=0 immediately.
  - No done pulse follows.
  - The next start with a=2, b=3 yields 6.
- Randomised a/b over 200 operations against the a*b reference model; the product must hold stable between done pulses.
